// File: rtl/eth_wbm_arbiter_pkg.sv
// rtl/eth_wbm_arbiter_pkg.sv - shared types and constants for the WISHBONE master arbiter
// Package eth_wbm_pkg: FSM state enum, grant enum, CTI/BTE burst codes.
package eth_wbm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TX_XFER = 2'd1,
        ST_RX_XFER = 2'd2
    } state_e;

    typedef enum logic {
        GNT_TX = 1'b0,
        GNT_RX = 1'b1
    } grant_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/eth_wbm_arbiter_if.sv
// rtl/eth_wbm_arbiter_if.sv - WISHBONE master bus bundle shared by arbiter and slave
// Signals keep the MAC pin names; _o/_i are from the master's point of view.
// master modport: drives adr/sel/we/dat_o/cyc/stb, receives dat_i/ack/err.
// slave modport: the reverse.
// Optional macro ETH_WB_BURST_EN adds m_wb_cti_o and m_wb_bte_o.
interface eth_wbm_arbiter_if;

    logic [31:0] m_wb_adr_o;
    logic [3:0]  m_wb_sel_o;
    logic        m_wb_we_o;
    logic [31:0] m_wb_dat_o;
    logic [31:0] m_wb_dat_i;
    logic        m_wb_cyc_o;
    logic        m_wb_stb_o;
    logic        m_wb_ack_i;
    logic        m_wb_err_i;
`ifdef ETH_WB_BURST_EN
    logic [2:0]  m_wb_cti_o;
    logic [1:0]  m_wb_bte_o;

    modport master (
        output m_wb_adr_o, m_wb_sel_o, m_wb_we_o, m_wb_dat_o,
        output m_wb_cyc_o, m_wb_stb_o, m_wb_cti_o, m_wb_bte_o,
        input  m_wb_dat_i, m_wb_ack_i, m_wb_err_i
    );

    modport slave (
        input  m_wb_adr_o, m_wb_sel_o, m_wb_we_o, m_wb_dat_o,
        input  m_wb_cyc_o, m_wb_stb_o, m_wb_cti_o, m_wb_bte_o,
        output m_wb_dat_i, m_wb_ack_i, m_wb_err_i
    );
`else
    modport master (
        output m_wb_adr_o, m_wb_sel_o, m_wb_we_o, m_wb_dat_o,
        output m_wb_cyc_o, m_wb_stb_o,
        input  m_wb_dat_i, m_wb_ack_i, m_wb_err_i
    );

    modport slave (
        input  m_wb_adr_o, m_wb_sel_o, m_wb_we_o, m_wb_dat_o,
        input  m_wb_cyc_o, m_wb_stb_o,
        output m_wb_dat_i, m_wb_ack_i, m_wb_err_i
    );
`endif

endinterface

// File: rtl/eth_wbm_arbiter_watchdog.sv
// rtl/eth_wbm_arbiter_watchdog.sv - no-ack watchdog counter for the WISHBONE master
// Ports: clk, rst (async, active-high), clr_i (zero the count, wins over en_i),
// en_i (count this cycle), expire_o (this is the TIMEOUT-th cycle without ack).
// TIMEOUT = 0 disables expiry.
module eth_wbm_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = 16;
    localparam logic [CW-1:0] LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Saturates at LIMIT so a held-off abort can never wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q counts prior idle cycles, so expiring at LIMIT marks the TIMEOUT-th one.
    assign expire_o = (TIMEOUT != 0) && en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/eth_wbm_arbiter.sv
// rtl/eth_wbm_arbiter.sv - round-robin share of the MAC WISHBONE master between TX fetch and RX store
// Ports: wb_clk_i/wb_rst_i (async active-high); TX requester tx_req/adr/len in,
// tx_dat/tx_dat_vld/tx_done/tx_err out; RX requester rx_req/adr/len/sel/dat in,
// rx_dat_rd/rx_done/rx_err out; m_wb master modport to the bus pins.
// Optional macro ETH_WB_BURST_EN: drives registered-burst cti/bte on the bus.
module eth_wbm_arbiter
    import eth_wbm_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     tx_req_i,
    input  logic [29:0]              tx_adr_i,
    input  logic [2:0]               tx_len_i,
    output logic [31:0]              tx_dat_o,
    output logic                     tx_dat_vld_o,
    output logic                     tx_done_o,
    output logic                     tx_err_o,
    input  logic                     rx_req_i,
    input  logic [29:0]              rx_adr_i,
    input  logic [2:0]               rx_len_i,
    input  logic [3:0]               rx_sel_i,
    input  logic [31:0]              rx_dat_i,
    output logic                     rx_dat_rd_o,
    output logic                     rx_done_o,
    output logic                     rx_err_o,
    eth_wbm_arbiter_if.master        m_wb
);

    localparam logic [2:0] MAX_LEN = 3'(MAX_BURST);

    function automatic logic [2:0] clamp_len(input logic [2:0] len);
        if (len == 3'd0) begin
            return 3'd1;
        end
        if (len > MAX_LEN) begin
            return MAX_LEN;
        end
        return len;
    endfunction

    state_e      state_q;
    grant_e      last_q;
    logic [29:0] adr_q;
    logic [2:0]  rem_q;
    logic [3:0]  sel_q;
    logic        we_q;
    logic        cyc_q;
    logic [31:0] tx_dat_q;
    logic        tx_dat_vld_q;
    logic        tx_done_q;
    logic        tx_err_q;
    logic        rx_done_q;
    logic        rx_err_q;

    logic in_xfer;
    logic beat_ack;
    logic abort;
    logic recover;
    logic wd_expire;

    assign in_xfer  = (state_q != ST_IDLE);
    // Err beats the ack in the same cycle; that word is not counted.
    assign beat_ack = in_xfer && m_wb.m_wb_ack_i && !m_wb.m_wb_err_i;
    assign abort    = in_xfer && (m_wb.m_wb_err_i || (wd_expire && !m_wb.m_wb_ack_i));
    // The first IDLE cycle carries the done/err pulse while the finished
    // requester still holds its request, so arbitration waits one cycle.
    assign recover  = tx_done_q || tx_err_q || rx_done_q || rx_err_q;

    eth_wbm_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .clr_i    (!in_xfer || m_wb.m_wb_ack_i),
        .en_i     (in_xfer),
        .expire_o (wd_expire)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= ST_IDLE;
            last_q       <= GNT_TX;
            adr_q        <= '0;
            rem_q        <= '0;
            sel_q        <= '0;
            we_q         <= 1'b0;
            cyc_q        <= 1'b0;
            tx_dat_q     <= '0;
            tx_dat_vld_q <= 1'b0;
            tx_done_q    <= 1'b0;
            tx_err_q     <= 1'b0;
            rx_done_q    <= 1'b0;
            rx_err_q     <= 1'b0;
        end else begin
            tx_dat_vld_q <= 1'b0;
            tx_done_q    <= 1'b0;
            tx_err_q     <= 1'b0;
            rx_done_q    <= 1'b0;
            rx_err_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!recover) begin
                        if (rx_req_i && (!tx_req_i || (last_q == GNT_TX))) begin
                            state_q <= ST_RX_XFER;
                            last_q  <= GNT_RX;
                            adr_q   <= rx_adr_i;
                            rem_q   <= clamp_len(rx_len_i);
                            sel_q   <= rx_sel_i;
                            we_q    <= 1'b1;
                            cyc_q   <= 1'b1;
                        end else if (tx_req_i) begin
                            state_q <= ST_TX_XFER;
                            last_q  <= GNT_TX;
                            adr_q   <= tx_adr_i;
                            rem_q   <= clamp_len(tx_len_i);
                            sel_q   <= 4'hF;
                            we_q    <= 1'b0;
                            cyc_q   <= 1'b1;
                        end
                    end
                end
                ST_TX_XFER, ST_RX_XFER: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        cyc_q   <= 1'b0;
                        we_q    <= 1'b0;
                        if (state_q == ST_TX_XFER) begin
                            tx_err_q <= 1'b1;
                        end else begin
                            rx_err_q <= 1'b1;
                        end
                    end else if (beat_ack) begin
                        adr_q <= adr_q + 30'd1;
                        rem_q <= rem_q - 3'd1;
                        if (state_q == ST_TX_XFER) begin
                            tx_dat_q     <= m_wb.m_wb_dat_i;
                            tx_dat_vld_q <= 1'b1;
                        end
                        if (rem_q == 3'd1) begin
                            state_q <= ST_IDLE;
                            cyc_q   <= 1'b0;
                            we_q    <= 1'b0;
                            if (state_q == ST_TX_XFER) begin
                                tx_done_q <= 1'b1;
                            end else begin
                                rx_done_q <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cyc_q   <= 1'b0;
                    we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign m_wb.m_wb_adr_o = {adr_q, 2'b00};
    assign m_wb.m_wb_sel_o = sel_q;
    assign m_wb.m_wb_we_o  = we_q;
    assign m_wb.m_wb_dat_o = rx_dat_i;
    assign m_wb.m_wb_cyc_o = cyc_q;
    assign m_wb.m_wb_stb_o = cyc_q;

`ifdef ETH_WB_BURST_EN
    assign m_wb.m_wb_cti_o = !cyc_q ? CTI_CLASSIC : ((rem_q == 3'd1) ? CTI_EOB : CTI_INCR);
    assign m_wb.m_wb_bte_o = BTE_LINEAR;
`endif

    assign tx_dat_o     = tx_dat_q;
    assign tx_dat_vld_o = tx_dat_vld_q;
    assign tx_done_o    = tx_done_q;
    assign tx_err_o     = tx_err_q;
    assign rx_dat_rd_o  = beat_ack && (state_q == ST_RX_XFER);
    assign rx_done_o    = rx_done_q;
    assign rx_err_o     = rx_err_q;

endmodule

// File: tb/tb_eth_wbm_arbiter.sv
// tb/tb_eth_wbm_arbiter.sv - scoreboard bench for eth_wbm_arbiter
module tb_eth_wbm_arbiter;
    import eth_wbm_pkg::*;

    localparam logic [31:0] RXBASE = 32'hC0DE_0000;
    localparam int END_TX_DONE = 0;
    localparam int END_TX_ERR  = 1;
    localparam int END_RX_DONE = 2;
    localparam int END_RX_ERR  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_req = 1'b0;
    logic [29:0] tx_adr = '0;
    logic [2:0]  tx_len = '0;
    logic [31:0] tx_dat;
    logic        tx_dat_vld, tx_done, tx_err;
    logic        rx_req = 1'b0;
    logic [29:0] rx_adr = '0;
    logic [2:0]  rx_len = '0;
    logic [3:0]  rx_sel = 4'h0;
    logic [31:0] rx_dat = RXBASE;
    logic        rx_dat_rd, rx_done, rx_err;

    eth_wbm_arbiter_if bus ();

    eth_wbm_arbiter dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .tx_req_i     (tx_req),
        .tx_adr_i     (tx_adr),
        .tx_len_i     (tx_len),
        .tx_dat_o     (tx_dat),
        .tx_dat_vld_o (tx_dat_vld),
        .tx_done_o    (tx_done),
        .tx_err_o     (tx_err),
        .rx_req_i     (rx_req),
        .rx_adr_i     (rx_adr),
        .rx_len_i     (rx_len),
        .rx_sel_i     (rx_sel),
        .rx_dat_i     (rx_dat),
        .rx_dat_rd_o  (rx_dat_rd),
        .rx_done_o    (rx_done),
        .rx_err_o     (rx_err),
        .m_wb         (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        last;
    } beat_t;

    beat_t       exp_beat_q[$];
    logic [31:0] exp_txd_q[$];
    int          exp_end_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // slave / requester model state
    bit resp_en   = 1'b1;
    int err_beat  = 0;
    int beat_n    = 0;
    int rx_idx    = 0;
    bit rx_adv    = 1'b0;
    int exp_rx_idx = 0;

    // monitor state
    int cyc_n = 0, rise_n = 0, tx_err_n = 0;
    int cyc_run = 0, low_run = 0, last_cyc_len = 0;
    int rx_rd_cnt = 0;
    bit cyc_prev = 1'b0, have_prev = 1'b0, err_chk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Queue the expected bus beats, TX data and end pulse of one transfer.
    task automatic push_xfer(input logic we, input logic [29:0] adr, input logic [3:0] sel,
                             input int plan, input int nacked, input bit err);
        logic [29:0] a;
        a = adr;
        for (int i = 0; i < nacked; i++) begin
            beat_t b;
            b.we   = we;
            b.adr  = {a, 2'b00};
            b.dat  = we ? (RXBASE + 32'(exp_rx_idx)) : 32'h0;
            b.sel  = we ? sel : 4'hF;
            b.last = (i == plan - 1);
            if (we) exp_rx_idx++;
            else    exp_txd_q.push_back(~{a, 2'b00});
            exp_beat_q.push_back(b);
            a = a + 30'd1;
        end
        if (we) exp_end_q.push_back(err ? END_RX_ERR : END_RX_DONE);
        else    exp_end_q.push_back(err ? END_TX_ERR : END_TX_DONE);
    endtask

    task automatic wait_end(input bit is_rx, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (is_rx ? (rx_done || rx_err) : (tx_done || tx_err)) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL wait_end: no end pulse for %s within %0d cycles", is_rx ? "rx" : "tx", budget);
    endtask

    task automatic run_tx(input logic [29:0] adr, input logic [2:0] len, input int budget);
        tx_adr = adr; tx_len = len; tx_req = 1'b1;
        wait_end(1'b0, budget);
        tx_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_rx(input logic [29:0] adr, input logic [2:0] len, input logic [3:0] sel);
        rx_adr = adr; rx_len = len; rx_sel = sel; rx_req = 1'b1;
        wait_end(1'b1, 100);
        rx_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // WISHBONE slave: responds in the same cycle as stb; read data = ~address.
    initial begin
        bus.m_wb_ack_i = 1'b0;
        bus.m_wb_err_i = 1'b0;
        bus.m_wb_dat_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rx_adv) begin
                rx_idx++;
                rx_dat = RXBASE + 32'(rx_idx);
                rx_adv = 1'b0;
            end
            bus.m_wb_ack_i = 1'b0;
            bus.m_wb_err_i = 1'b0;
            if (bus.m_wb_cyc_o && bus.m_wb_stb_o) begin
                if (resp_en) begin
                    beat_n++;
                    if (beat_n == err_beat) bus.m_wb_err_i = 1'b1;
                    else                    bus.m_wb_ack_i = 1'b1;
                    bus.m_wb_dat_i = ~bus.m_wb_adr_o;
                end
            end else begin
                beat_n = 0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an output event.
    initial begin
        forever begin
            @(negedge clk);
            cyc_n++;
            if (err_chk) begin
                check("cyc_low_after_err", {31'b0, bus.m_wb_cyc_o}, 32'd0);
                err_chk = 1'b0;
            end
            if (bus.m_wb_cyc_o) begin
                if (!cyc_prev) begin
                    rise_n = cyc_n;
                    if (have_prev) check("cyc_gap_ge1", {31'b0, (low_run >= 1)}, 32'd1);
                    have_prev = 1'b1;
                    cyc_run = 0;
                end
                cyc_run++;
            end else begin
                if (cyc_prev) begin
                    last_cyc_len = cyc_run;
                    low_run = 0;
                end
                low_run++;
            end
            cyc_prev = bus.m_wb_cyc_o;
            if (bus.m_wb_cyc_o && bus.m_wb_stb_o && bus.m_wb_err_i) err_chk = 1'b1;

            if (bus.m_wb_cyc_o && bus.m_wb_stb_o && bus.m_wb_ack_i && !bus.m_wb_err_i) begin
                if (exp_beat_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL beat: unexpected beat at adr 0x%08h", bus.m_wb_adr_o);
                end else begin
                    beat_t b;
                    b = exp_beat_q.pop_front();
                    check("beat_adr", bus.m_wb_adr_o, b.adr);
                    check("beat_we", {31'b0, bus.m_wb_we_o}, {31'b0, b.we});
                    check("beat_sel", {28'b0, bus.m_wb_sel_o}, {28'b0, b.sel});
                    check("rx_dat_rd", {31'b0, rx_dat_rd}, {31'b0, b.we});
                    if (b.we) check("beat_wdat", bus.m_wb_dat_o, b.dat);
`ifdef ETH_WB_BURST_EN
                    check("beat_cti", {29'b0, bus.m_wb_cti_o}, {29'b0, (b.last ? CTI_EOB : CTI_INCR)});
                    check("beat_bte", {30'b0, bus.m_wb_bte_o}, {30'b0, BTE_LINEAR});
`endif
                end
            end else if (rx_dat_rd) begin
                check("rx_dat_rd_spurious", 32'd1, 32'd0);
            end
            if (rx_dat_rd) begin
                rx_rd_cnt++;
                rx_adv = 1'b1;
            end

            if (tx_dat_vld) begin
                if (exp_txd_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL tx_dat: unexpected tx_dat_vld_o with 0x%08h", tx_dat);
                end else begin
                    check("tx_dat", tx_dat, exp_txd_q.pop_front());
                end
            end

            for (int k = 0; k < 4; k++) begin
                logic p;
                case (k)
                    0: p = tx_done;
                    1: p = tx_err;
                    2: p = rx_done;
                    default: p = rx_err;
                endcase
                if (p) begin
                    if (k == END_TX_ERR) tx_err_n = cyc_n;
                    if (exp_end_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL end_pulse: unexpected end code %0d", k);
                    end else begin
                        check("end_pulse", 32'(k), 32'(exp_end_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        int rd0;
        // Reset state.
        @(negedge clk);
        check("rst_cyc", {31'b0, bus.m_wb_cyc_o}, 32'd0);
        check("rst_stb", {31'b0, bus.m_wb_stb_o}, 32'd0);
        check("rst_we", {31'b0, bus.m_wb_we_o}, 32'd0);
        check("rst_adr", bus.m_wb_adr_o, 32'd0);
        check("rst_sel", {28'b0, bus.m_wb_sel_o}, 32'd0);
        check("rst_tx_dat", tx_dat, 32'd0);
        check("rst_pulses", {26'b0, tx_dat_vld, tx_done, tx_err, rx_done, rx_err, rx_dat_rd}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // TX only, 4 words at 0x100, ack every cycle.
        push_xfer(1'b0, 30'h100, 4'h0, 4, 4, 1'b0);
        run_tx(30'h100, 3'd4, 100);
        check("tx4_cyc_len", 32'(last_cyc_len), 32'd4);

        // Both requesting from reset: RX, TX, then RX again.
        do_reset();
        rd0 = rx_rd_cnt;
        push_xfer(1'b1, 30'h080, 4'h3, 2, 2, 1'b0);
        push_xfer(1'b0, 30'h0C0, 4'h0, 1, 1, 1'b0);
        push_xfer(1'b1, 30'h0A0, 4'h3, 2, 2, 1'b0);
        fork
            begin
                tx_adr = 30'h0C0; tx_len = 3'd1; tx_req = 1'b1;
                wait_end(1'b0, 100);
                tx_req = 1'b0;
            end
            begin
                rx_adr = 30'h080; rx_len = 3'd2; rx_sel = 4'h3; rx_req = 1'b1;
                wait_end(1'b1, 100);
                rx_req = 1'b0;
                @(negedge clk);
                rx_adr = 30'h0A0; rx_req = 1'b1;
                wait_end(1'b1, 100);
                rx_req = 1'b0;
            end
        join
        @(negedge clk);
        check("both_rx_rd_cnt", 32'(rx_rd_cnt - rd0), 32'd4);

        // RX len 3 with bus error on the second beat.
        rd0 = rx_rd_cnt;
        err_beat = 2;
        push_xfer(1'b1, 30'h200, 4'hC, 3, 1, 1'b1);
        run_rx(30'h200, 3'd3, 4'hC);
        err_beat = 0;
        check("err_rx_rd_cnt", 32'(rx_rd_cnt - rd0), 32'd1);

        // TX len 2 with no ack: watchdog abort 255 cycles after stb rises.
        resp_en = 1'b0;
        push_xfer(1'b0, 30'h300, 4'h0, 2, 0, 1'b1);
        run_tx(30'h300, 3'd2, 400);
        resp_en = 1'b1;
        check("timeout_cycles", 32'(tx_err_n - rise_n), 32'd255);

        // Address wrap, len 0 -> 1 word, len 7 -> 4 words.
        push_xfer(1'b0, 30'h3FFF_FFFF, 4'h0, 2, 2, 1'b0);
        run_tx(30'h3FFF_FFFF, 3'd2, 100);
        push_xfer(1'b1, 30'h040, 4'h5, 1, 1, 1'b0);
        run_rx(30'h040, 3'd0, 4'h5);
        check("len0_cyc_len", 32'(last_cyc_len), 32'd1);
        push_xfer(1'b0, 30'h500, 4'h0, 4, 4, 1'b0);
        run_tx(30'h500, 3'd7, 100);
        check("len7_cyc_len", 32'(last_cyc_len), 32'd4);

        // Reset mid-burst: outputs drop without a clock edge.
        resp_en = 1'b0;
        tx_adr = 30'h600; tx_len = 3'd4; tx_req = 1'b1;
        for (int i = 0; i < 20 && !bus.m_wb_cyc_o; i++) @(negedge clk);
        check("midrst_cyc_before", {31'b0, bus.m_wb_cyc_o}, 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_cyc", {31'b0, bus.m_wb_cyc_o}, 32'd0);
        check("midrst_stb", {31'b0, bus.m_wb_stb_o}, 32'd0);
        tx_req = 1'b0;
        resp_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push_xfer(1'b1, 30'h700, 4'hF, 1, 1, 1'b0);
        push_xfer(1'b0, 30'h710, 4'h0, 1, 1, 1'b0);
        fork
            begin
                tx_adr = 30'h710; tx_len = 3'd1; tx_req = 1'b1;
                wait_end(1'b0, 100);
                tx_req = 1'b0;
            end
            begin
                rx_adr = 30'h700; rx_len = 3'd1; rx_sel = 4'hF; rx_req = 1'b1;
                wait_end(1'b1, 100);
                rx_req = 1'b0;
            end
        join
        repeat (3) @(negedge clk);

        check("beat_q_empty", 32'(exp_beat_q.size()), 32'd0);
        check("txd_q_empty", 32'(exp_txd_q.size()), 32'd0);
        check("end_q_empty", 32'(exp_end_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
